if_id_fetch_queue: RTL

//  Parametrised IF/ID pipeline stage with valid/ready handshakes on both sides.

---
 rtl/if_id_fetch_queue.sv | 93 +++++++++
 1 files changed

// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: a small FIFO of (pc, instruction) pairs between fetch and decode.
// Valid/ready handshakes on both sides; flush empties the queue and decode then sees NOP_INSTR.
module if_id_fetch_queue #(
   parameter int unsigned                 PC_DATA_WIDTH     = 20,
   parameter int unsigned                 INSTRUCTION_WIDTH = 32,
   parameter int unsigned                 DEPTH             = 2,
   parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR        = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         if_valid,
   output logic                         if_ready,
   input  logic [PC_DATA_WIDTH-1:0]     pc_in,
   input  logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_in,
   input  logic                         id_ready,
   output logic                         id_valid,
   output logic [PC_DATA_WIDTH-1:0]     new_pc_out,
   output logic [INSTRUCTION_WIDTH-1:0] instruction_reg_out,
   output logic [$clog2(DEPTH):0]       count_out
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   // Storage is deliberately not reset; count_q alone decides which slots are meaningful.
   logic [PC_DATA_WIDTH-1:0]     pc_mem   [DEPTH];
   logic [INSTRUCTION_WIDTH-1:0] inst_mem [DEPTH];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push;
   logic            pop;

   // Handshake flags come from registered count only, so flush/id_ready never reach if_ready.
   always_comb begin
      if_ready = (count_q != CntW'(DEPTH));
      id_valid = (count_q != '0);
      push     = if_valid & if_ready & ~flush;
      pop      = id_valid & id_ready & ~flush;
   end

   // Next-state pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   // Pointer and count registers; async reset drops every entry at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Write the accepted pair into the tail slot.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= pc_in;
         inst_mem[wr_ptr_q] <= inst_mem_data_in;
      end
   end

   // Head entry to decode; an empty queue presents pc 0 and the NOP.
   always_comb begin
      count_out = count_q;
      if (id_valid) begin
         new_pc_out          = pc_mem[rd_ptr_q];
         instruction_reg_out = inst_mem[rd_ptr_q];
      end else begin
         new_pc_out          = '0;
         instruction_reg_out = NOP_INSTR;
      end
   end

endmodule
